// File: rtl/nms_thin.sv
// rtl/nms_thin.sv - streaming 3x3 non-maximum suppression for gradient magnitudes
// The output for a centre pixel is taken from the registered 3x3 window in the cycle after the step that completes it.
module nms_thin #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] magnitude,
  input  logic [3:0]  tan,
  output logic        out_valid,
  output logic [15:0] edge_mag,
  output logic        frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = $clog2(IMG_H + 2);
  localparam int FW = $clog2(IMG_W + 1);
  localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_ONE    = CW'(1);
  localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);
  localparam logic [RW-1:0] ROW_TWO    = RW'(2);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(IMG_W);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [FW-1:0] fcnt;

  logic [19:0] lb1 [IMG_W];
  logic [19:0] lb2 [IMG_W];
  // Window index r*3+c: 0 NW, 1 N, 2 NE, 3 W, 4 centre, 5 E, 6 SW, 7 S, 8 SE.
  logic [19:0] win [9];

  logic        accept, step, last_pix, flush_end;
  logic [19:0] pix_in;

  logic [CW-1:0] ccol;
  logic [RW-1:0] crow;
  logic          cvalid, cborder;

  logic        ov, bord_q, done_pend;
  logic [15:0] held, thin;
  logic [15:0] c_mag, a_mag, b_mag;
  logic        dir_ok;

  assign in_ready  = (state != S_FLUSH);
  assign accept    = in_valid && in_ready;
  assign step      = accept || (state == S_FLUSH);
  assign last_pix  = (row == ROW_LAST) && (col == COL_LAST);
  assign flush_end = (state == S_FLUSH) && (fcnt == FLUSH_LAST);
  assign pix_in    = (state == S_FLUSH) ? 20'd0 : {magnitude, tan};

  // The newest pixel sits bottom-right, so the centre is one row up and one column left.
  always_comb begin
    ccol   = col - COL_ONE;
    crow   = row - ROW_ONE;
    cvalid = (row >= ROW_ONE);
    if (col == '0) begin
      ccol   = COL_LAST;
      crow   = row - ROW_TWO;
      cvalid = (row >= ROW_TWO);
    end
    cborder = (crow == '0) || (crow == ROW_LAST) || (ccol == '0) || (ccol == COL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      row        <= '0;
      col        <= '0;
      fcnt       <= '0;
      ov         <= 1'b0;
      bord_q     <= 1'b0;
      held       <= '0;
      done_pend  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      ov         <= step && cvalid;
      frame_done <= done_pend;
      done_pend  <= 1'b0;
      if (step) bord_q <= cborder;
      if (ov) held <= thin;

      case (state)
        S_IDLE:  if (accept) state <= S_RUN;
        S_RUN:   if (accept && last_pix) state <= S_FLUSH;
        S_FLUSH: begin
          fcnt <= fcnt + FLUSH_ONE;
          if (flush_end) begin
            state     <= S_IDLE;
            fcnt      <= '0;
            done_pend <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (flush_end) begin
        row <= '0;
        col <= '0;
      end else if (step) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= row + ROW_ONE;
        end else begin
          col <= col + COL_ONE;
        end
      end
    end
  end

  // Line buffers and window are deliberately not reset; border suppression hides stale data.
  always_ff @(posedge clk) begin
    if (step) begin
      lb2[col] <= lb1[col];
      lb1[col] <= pix_in;
      win[0]   <= win[1];
      win[1]   <= win[2];
      win[2]   <= lb2[col];
      win[3]   <= win[4];
      win[4]   <= win[5];
      win[5]   <= lb1[col];
      win[6]   <= win[7];
      win[7]   <= win[8];
      win[8]   <= pix_in;
    end
  end

  always_comb begin
    c_mag  = win[4][19:4];
    a_mag  = '0;
    b_mag  = '0;
    dir_ok = 1'b1;
    case (win[4][3:0])
      4'b0000, 4'b0100:           begin a_mag = win[3][19:4]; b_mag = win[5][19:4]; end
      4'b0001, 4'b0010:           begin a_mag = win[2][19:4]; b_mag = win[6][19:4]; end
      4'b0101, 4'b0110:           begin a_mag = win[0][19:4]; b_mag = win[8][19:4]; end
      4'b0011, 4'b0111, 4'b1000:  begin a_mag = win[1][19:4]; b_mag = win[7][19:4]; end
      default:                    dir_ok = 1'b0;
    endcase
    thin = (dir_ok && !bord_q && (c_mag > a_mag) && (c_mag >= b_mag)) ? c_mag : 16'd0;
  end

  assign out_valid = ov;
  assign edge_mag  = ov ? thin : held;

endmodule

// File: doc/nms_thin.md
NMS_THIN -- requirements
Module: nms_thin

Interface
REQ-001 SHALL have parameter IMG_W, default 64: pixels per line; legal range 4..1024.
REQ-002 SHALL have parameter IMG_H, default 64: lines per frame; legal range 3..1024.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  a gradient pixel is offered this cycle.
REQ-006 SHALL have port in_ready  output  1  the block accepts a pixel this cycle.
REQ-007 SHALL have port magnitude  input  16  unsigned gradient magnitude of the offered pixel.
REQ-008 SHALL have port tan  input  4  quantised direction code of the offered pixel.
REQ-009 SHALL have port out_valid  output  1  edge_mag is valid this cycle; there is no backpressure.
REQ-010 SHALL have port edge_mag  output  16  thinned magnitude: the centre value if kept, else 0.
REQ-011 SHALL have port frame_done  output  1  one-cycle pulse after the last output of a frame.

Function
REQ-012 SHALL accept a pixel only when in_valid and in_ready are both 1; pixels arrive in raster order.
REQ-013 SHALL implement the state machine IDLE -> RUN on the first accepted pixel, RUN -> FLUSH on acceptance of pixel IMG_W*IMG_H-1, and FLUSH -> IDLE after IMG_W+1 flush steps.
REQ-014 SHALL drive in_ready=1 in IDLE and RUN, and in_ready=0 in FLUSH.
REQ-015 SHALL store the previous two lines in two line buffers, IMG_W entries of 20 bits each ({magnitude, tan}), and keep a 3x3 window register.
REQ-016 SHALL, in FLUSH, advance the pipeline by one step per cycle with a zero pixel substituted for the input.
REQ-017 SHALL produce the result for raster pixel k with out_valid=1 in the cycle after the acceptance or flush step of pixel k+IMG_W+1.
REQ-018 SHALL emit exactly IMG_W*IMG_H outputs per frame, in raster order.
REQ-019 SHALL select the neighbour pair (A = earlier in raster order, B = later) from the centre tan code:
- 0000, 0100 -> W, E
- 0001, 0010 -> NE, SW
- 0101, 0110 -> NW, SE
- 0011, 0111, 1000 -> N, S
REQ-020 SHALL output 0 for tan codes 1001..1111.
REQ-021 SHALL keep the centre if and only if mag_c > mag_A and mag_c >= mag_B, all compared as unsigned 16-bit values; a kept pixel outputs edge_mag = mag_c, otherwise 0.
REQ-022 SHALL output edge_mag = 0 for every border pixel (row 0, row IMG_H-1, column 0, column IMG_W-1), regardless of the comparison.
REQ-023 SHALL derive border status from internal row and column counters; the column counter wraps IMG_W-1 -> 0 and increments the row counter.
REQ-024 SHALL never form a window that mixes pixels from the end of one line with the start of the next (no wrap-around of window data across lines).
REQ-025 SHALL pulse frame_done for one cycle, in the cycle after the final out_valid of a frame.
REQ-026 SHALL accept the first pixel of the next frame in the cycle after FLUSH exits to IDLE.
REQ-027 SHALL hold edge_mag at its last value whenever out_valid=0.

Reset
REQ-028 SHALL, on rst=1, set the state to IDLE, clear the row and column counters and the flush counter, and drive out_valid=0, edge_mag=0, frame_done=0 and in_ready=1 in the following cycle.
REQ-029 SHALL abandon a partial frame when rst is asserted mid-frame (RUN or FLUSH), with no further outputs for that frame.
REQ-030 SHALL NOT clear line buffer contents on reset; correctness SHALL rely on the border rule in REQ-022.

Verification
REQ-031 SHALL be verified with IMG_W=8, IMG_H=8 and all pixels mag=100, tan=0000: 64 outputs, all 0, because mag_c > mag_A fails; frame_done pulses once.
REQ-032 SHALL be verified with a single pixel mag=500, tan=0000 at (3,3) in a zero frame: output (3,3)=500, all others 0; first out_valid 10 cycles after the first accept.
REQ-033 SHALL be verified with column 4 = 300 and all else 0, tan=0000 everywhere: rows 1..6 output 300 at column 4; rows 0 and 7 output 0.
REQ-034 SHALL be verified with centre (3,3)=200, tan=0101, NW=250, all else 0: output (3,3)=0; with the same frame but tan=0001: output (3,3)=200.
REQ-035 SHALL be verified by gapping in_valid randomly across a full frame: outputs are identical to the gap-free run, and in_ready=0 for exactly 9 cycles during FLUSH.
REQ-036 SHALL be verified by asserting rst after pixel 30 and then sending a fresh frame: no outputs from the old frame, 64 correct outputs for the new frame, and one frame_done.
